sva_range_seq_checker: RTL and testbench
========================================

// Module: sva_range_seq_checker
// PURPOSE
// - Native gclk-domain checker for the property  trig |-> ##[MIN_DLY:MAX_DLY] cons.
// - Tracks up to NUM_SLOTS overlapping attempts in parallel.
// - Adds a delay window, attempt-overflow detection, flush and saturating statistics.
// - Sits beside the DUT in generated SVA test harnesses; no sys_clk oversampling.
// PARAMETERS
// MIN_DLY    3   first age (gclk edges after trigger) at which cons is accepted; >=1
// MAX_DLY    3   last accepted age; >=MIN_DLY; fail decided at this age
// NUM_SLOTS  4   max concurrent in-flight attempts
// CNT_WIDTH  16  width of pass/fail/overflow statistic counters
// PORTS
// gclk        in   1          user clock; all logic on posedge
// grst        in   1          reset, asynchronous, active-high
// en          in   1          1: trig may start attempts; 0: no new attempts, in-flight ones continue
// flush       in   1          sync; drops all in-flight attempts, no succ/fail generated
// trig        in   1          antecedent (sampled on posedge gclk)
// cons        in   1          consequent (sampled on posedge gclk)
// succ        out  1          registered 1-cycle pulse: >=1 attempt passed at this edge
// fail        out  1          registered 1-cycle pulse: >=1 attempt failed at this edge
// ovf         out  1          registered 1-cycle pulse: trig dropped, all slots busy
// busy        out  1          any slot occupied (registered)
// inflight    out  $clog2(NUM_SLOTS+1)  occupied slot count
// pass_cnt    out  CNT_WIDTH  saturating count of passed attempts
// fail_cnt    out  CNT_WIDTH  saturating count of failed attempts
// ovf_cnt     out  CNT_WIDTH  saturating count of dropped triggers
// BEHAVIOUR
// - grst: all slots FREE, ages 0, all outputs and counters 0. Async assert clears mid-attempt; no pulses.
// - Per-slot FSM: FREE -> WAIT (age<MIN_DLY) -> WINDOW (MIN_DLY<=age<=MAX_DLY) -> FREE.
//   - Age counter width $clog2(MAX_DLY+1); increments each edge while occupied; never wraps.
// - Start: edge E with en&trig&!flush allocates the lowest-index slot FREE before E; age=0 at E.
//   - A slot freed at edge E is not reusable until edge E+1.
//   - No free slot: attempt dropped, ovf=1 after E, ovf_cnt+1.
// - Age k evaluated at edge E+k:
//   - k<MIN_DLY: cons ignored.
//   - MIN_DLY<=k<=MAX_DLY and cons=1: pass, slot FREE.
//   - k==MAX_DLY and cons=0: fail, slot FREE.
// - A trigger at edge E is never judged at E itself; cons at E only affects older attempts.
// - Several slots may resolve on one edge:
//   - succ/fail are OR of per-slot results.
//   - pass_cnt/fail_cnt add the per-edge popcount, saturating at 2^CNT_WIDTH-1.
//   - succ and fail may both be 1 on the same edge.
// - Latency: succ/fail/ovf high during the cycle after the deciding edge; counters update on the same edge.
// - flush=1 at edge E:
//   - All slots FREE at E; no succ/fail, no counter change.
//   - trig at E is ignored, not counted as ovf.
// - busy/inflight reflect slot state after the edge, including new allocation and releases.
// TESTING
// - MIN=MAX=3: trig@E0, cons@E3 -> succ=1 after E3 only, pass_cnt=1, busy low after E3.
// - MIN=MAX=3: trig@E0, cons=0 @E1..E3 -> fail=1 after E3, fail_cnt=1; cons@E4 has no effect.
// - MIN=2,MAX=4: trig@E0, cons@E1 and E3 -> E1 ignored, succ after E3.
//   - trig@E10, cons@E12 -> succ (lower bound).
//   - trig@E20, cons only @E25 -> fail after E24.
// - NUM_SLOTS=2,MAX=4: trig@E0,E1,E2 -> ovf after E2, ovf_cnt=1, inflight=2.
//   - With cons@E4,E5 -> two succ pulses, pass_cnt=2.
// - trig@E0..E2 (MIN=MAX=3); flush@E2 -> no succ/fail ever, inflight=0 after E2.
//   - grst pulse mid-attempt -> same result; all counters 0.
// - CNT_WIDTH=2, 5 passing attempts -> pass_cnt saturates at 3.
//   - trig every edge with cons=1 -> succ continuous once ages reach MIN.

Source files
------------

// File: rtl/sva_range_seq_checker.sv
// Checker for trig |-> ##[MIN_DLY:MAX_DLY] cons with up to NUM_SLOTS overlapping attempts.
// One slot FSM per in-flight attempt; the top allocates slots and keeps saturating statistics.

module sva_range_slot #(
    parameter int MIN_DLY = 3,
    parameter int MAX_DLY = 3,
    parameter int AW      = 2
) (
    input  logic gclk,
    input  logic grst,
    input  logic start_i,
    input  logic flush_i,
    input  logic cons_i,
    output logic occ_o,
    output logic occ_d_o,
    output logic pass_o,
    output logic fail_o
);
    typedef enum logic [1:0] {FREE, WAIT, WINDOW} state_t;

    state_t        state_q;
    logic [AW-1:0] age_q;
    logic [AW-1:0] age_d;
    logic          occ;

    // age_q holds the age reached at the previous edge; this edge judges age_q+1
    assign occ     = (state_q != FREE);
    assign age_d   = age_q + AW'(1);
    assign pass_o  = occ && !flush_i && cons_i && (age_d >= AW'(MIN_DLY));
    assign fail_o  = occ && !flush_i && !cons_i && (age_d == AW'(MAX_DLY));
    assign occ_o   = occ;
    assign occ_d_o = !flush_i && ((occ && !pass_o && !fail_o) || (!occ && start_i));

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            state_q <= FREE;
            age_q   <= '0;
        end else if (flush_i) begin
            state_q <= FREE;
            age_q   <= '0;
        end else begin
            case (state_q)
                FREE: begin
                    if (start_i) state_q <= WAIT;
                    age_q <= '0;
                end
                WAIT, WINDOW: begin
                    if (pass_o || fail_o) begin
                        state_q <= FREE;
                        age_q   <= '0;
                    end else begin
                        state_q <= (age_d >= AW'(MIN_DLY)) ? WINDOW : WAIT;
                        age_q   <= age_d;
                    end
                end
                default: begin
                    state_q <= FREE;
                    age_q   <= '0;
                end
            endcase
        end
    end
endmodule

module sva_range_seq_checker #(
    parameter int MIN_DLY   = 3,
    parameter int MAX_DLY   = 3,
    parameter int NUM_SLOTS = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                           gclk,
    input  logic                           grst,
    input  logic                           en,
    input  logic                           flush,
    input  logic                           trig,
    input  logic                           cons,
    output logic                           succ,
    output logic                           fail,
    output logic                           ovf,
    output logic                           busy,
    output logic [$clog2(NUM_SLOTS+1)-1:0] inflight,
    output logic [CNT_WIDTH-1:0]           pass_cnt,
    output logic [CNT_WIDTH-1:0]           fail_cnt,
    output logic [CNT_WIDTH-1:0]           ovf_cnt
);
    localparam int AW = $clog2(MAX_DLY + 1);
    localparam int IW = $clog2(NUM_SLOTS + 1);

    logic [NUM_SLOTS-1:0] occ, occ_nx, pass_v, fail_v, start_v;
    logic                 req, ovf_d;
    logic                 succ_q, fail_q, ovf_q, busy_q;
    logic [IW-1:0]        inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_WIDTH-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_WIDTH-1:0] ovf_cnt_q, ovf_cnt_d;

    function automatic logic [IW-1:0] popc(input logic [NUM_SLOTS-1:0] v);
        logic [IW-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_SLOTS; i++) n = n + IW'(v[i]);
        return n;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                     input logic [IW-1:0] n);
        logic [CNT_WIDTH+IW:0] s;
        s = {{(IW+1){1'b0}}, c} + {{(CNT_WIDTH+1){1'b0}}, n};
        return (s > {{(IW+1){1'b0}}, {CNT_WIDTH{1'b1}}}) ? {CNT_WIDTH{1'b1}} : s[CNT_WIDTH-1:0];
    endfunction

    assign req = en && trig && !flush;

    // Allocation looks only at occupancy before the edge, so a slot released now is not reused now
    always_comb begin
        logic found;
        start_v = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!found && !occ[i]) begin
                start_v[i] = req;
                found      = 1'b1;
            end
        end
    end

    assign ovf_d = req && (&occ);

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        sva_range_slot #(.MIN_DLY(MIN_DLY), .MAX_DLY(MAX_DLY), .AW(AW)) u_slot (
            .gclk    (gclk),
            .grst    (grst),
            .start_i (start_v[g]),
            .flush_i (flush),
            .cons_i  (cons),
            .occ_o   (occ[g]),
            .occ_d_o (occ_nx[g]),
            .pass_o  (pass_v[g]),
            .fail_o  (fail_v[g])
        );
    end

    assign inflight_d = popc(occ_nx);
    assign pass_cnt_d = sat_add(pass_cnt_q, popc(pass_v));
    assign fail_cnt_d = sat_add(fail_cnt_q, popc(fail_v));
    assign ovf_cnt_d  = sat_add(ovf_cnt_q, IW'(ovf_d));

    always_ff @(posedge gclk or posedge grst) begin
        if (grst) begin
            succ_q     <= 1'b0;
            fail_q     <= 1'b0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            inflight_q <= '0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            ovf_cnt_q  <= '0;
        end else begin
            succ_q     <= |pass_v;
            fail_q     <= |fail_v;
            ovf_q      <= ovf_d;
            busy_q     <= |occ_nx;
            inflight_q <= inflight_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            ovf_cnt_q  <= ovf_cnt_d;
        end
    end

    assign succ     = succ_q;
    assign fail     = fail_q;
    assign ovf      = ovf_q;
    assign busy     = busy_q;
    assign inflight = inflight_q;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
    assign ovf_cnt  = ovf_cnt_q;
endmodule

// File: tb/tb_sva_range_seq_checker.sv
// Directed bench: four checker instances with different delay windows, slot counts and
// counter widths share one stimulus stream; each test checks the instance it targets.

module tb_sva_range_seq_checker;
    logic gclk, grst, en, flush, trig, cons;
    int   total, bad;

    // a: MIN=MAX=3, 4 slots
    logic a_succ, a_fail, a_ovf, a_busy;
    logic [2:0]  a_inflight;
    logic [15:0] a_pass, a_failc, a_ovfc;
    // b: MIN=2, MAX=4
    logic b_succ, b_fail, b_ovf, b_busy;
    logic [2:0]  b_inflight;
    logic [15:0] b_pass, b_failc, b_ovfc;
    // c: MIN=MAX=4, 2 slots
    logic c_succ, c_fail, c_ovf, c_busy;
    logic [1:0]  c_inflight;
    logic [15:0] c_pass, c_failc, c_ovfc;
    // d: MIN=MAX=3, 2-bit counters
    logic d_succ, d_fail, d_ovf, d_busy;
    logic [2:0]  d_inflight;
    logic [1:0]  d_pass, d_failc, d_ovfc;

    sva_range_seq_checker #(.MIN_DLY(3), .MAX_DLY(3), .NUM_SLOTS(4), .CNT_WIDTH(16)) u_a (
        .gclk(gclk), .grst(grst), .en(en), .flush(flush), .trig(trig), .cons(cons),
        .succ(a_succ), .fail(a_fail), .ovf(a_ovf), .busy(a_busy), .inflight(a_inflight),
        .pass_cnt(a_pass), .fail_cnt(a_failc), .ovf_cnt(a_ovfc));
    sva_range_seq_checker #(.MIN_DLY(2), .MAX_DLY(4), .NUM_SLOTS(4), .CNT_WIDTH(16)) u_b (
        .gclk(gclk), .grst(grst), .en(en), .flush(flush), .trig(trig), .cons(cons),
        .succ(b_succ), .fail(b_fail), .ovf(b_ovf), .busy(b_busy), .inflight(b_inflight),
        .pass_cnt(b_pass), .fail_cnt(b_failc), .ovf_cnt(b_ovfc));
    sva_range_seq_checker #(.MIN_DLY(4), .MAX_DLY(4), .NUM_SLOTS(2), .CNT_WIDTH(16)) u_c (
        .gclk(gclk), .grst(grst), .en(en), .flush(flush), .trig(trig), .cons(cons),
        .succ(c_succ), .fail(c_fail), .ovf(c_ovf), .busy(c_busy), .inflight(c_inflight),
        .pass_cnt(c_pass), .fail_cnt(c_failc), .ovf_cnt(c_ovfc));
    sva_range_seq_checker #(.MIN_DLY(3), .MAX_DLY(3), .NUM_SLOTS(4), .CNT_WIDTH(2)) u_d (
        .gclk(gclk), .grst(grst), .en(en), .flush(flush), .trig(trig), .cons(cons),
        .succ(d_succ), .fail(d_fail), .ovf(d_ovf), .busy(d_busy), .inflight(d_inflight),
        .pass_cnt(d_pass), .fail_cnt(d_failc), .ovf_cnt(d_ovfc));

    initial gclk = 1'b0;
    always #5 gclk = ~gclk;

    // Inputs change 1ns after an edge, outputs are sampled at that same point
    task automatic tick(input logic t, input logic c);
        trig = t;
        cons = c;
        @(posedge gclk);
        #1;
    endtask

    task automatic do_reset();
        grst = 1'b1; en = 1'b1; flush = 1'b0; trig = 1'b0; cons = 1'b0;
        repeat (2) @(posedge gclk);
        #1 grst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({a_succ, a_fail, a_ovf, a_busy} !== 4'b0) begin bad++; $display("FAIL reset_flags got=%b want=0000", {a_succ, a_fail, a_ovf, a_busy}); end
        total++; if (a_inflight !== 3'd0) begin bad++; $display("FAIL reset_inflight got=%0d want=0", a_inflight); end
        total++; if ({a_pass, a_failc, a_ovfc} !== 48'd0) begin bad++; $display("FAIL reset_cnts got=%0d/%0d/%0d want=0", a_pass, a_failc, a_ovfc); end
        total++; if ({d_pass, d_failc, d_ovfc} !== 6'd0) begin bad++; $display("FAIL reset_cnts_d got=%b want=0", {d_pass, d_failc, d_ovfc}); end
    endtask

    task automatic test_exact_pass();
        do_reset();
        tick(1, 0);
        total++; if (a_busy !== 1'b1 || a_inflight !== 3'd1) begin bad++; $display("FAIL exact_alloc busy=%b inflight=%0d want 1/1", a_busy, a_inflight); end
        tick(0, 0); tick(0, 0);
        total++; if (a_succ !== 1'b0) begin bad++; $display("FAIL exact_early got=%b want=0", a_succ); end
        tick(0, 1);
        total++; if (a_succ !== 1'b1 || a_fail !== 1'b0) begin bad++; $display("FAIL exact_succ succ=%b fail=%b want 1/0", a_succ, a_fail); end
        total++; if (a_pass !== 16'd1 || a_busy !== 1'b0) begin bad++; $display("FAIL exact_cnt pass=%0d busy=%b want 1/0", a_pass, a_busy); end
        tick(0, 0);
        total++; if (a_succ !== 1'b0) begin bad++; $display("FAIL exact_pulse got=%b want=0", a_succ); end
    endtask

    task automatic test_exact_fail();
        do_reset();
        tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 0);
        total++; if (a_fail !== 1'b1 || a_failc !== 16'd1) begin bad++; $display("FAIL xfail fail=%b cnt=%0d want 1/1", a_fail, a_failc); end
        tick(0, 1);
        total++; if (a_succ !== 1'b0 || a_fail !== 1'b0 || a_pass !== 16'd0) begin bad++; $display("FAIL xfail_late succ=%b fail=%b pass=%0d want 0/0/0", a_succ, a_fail, a_pass); end
    endtask

    task automatic test_window();
        do_reset();
        tick(1, 0);
        tick(0, 1);
        total++; if (b_succ !== 1'b0) begin bad++; $display("FAIL win_ignore got=%b want=0", b_succ); end
        tick(0, 0); tick(0, 1);
        total++; if (b_succ !== 1'b1 || b_pass !== 16'd1) begin bad++; $display("FAIL win_mid succ=%b pass=%0d want 1/1", b_succ, b_pass); end
        tick(1, 0); tick(0, 0); tick(0, 1);
        total++; if (b_succ !== 1'b1 || b_pass !== 16'd2) begin bad++; $display("FAIL win_lower succ=%b pass=%0d want 1/2", b_succ, b_pass); end
        tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 0);
        total++; if (b_fail !== 1'b0) begin bad++; $display("FAIL win_nofail got=%b want=0", b_fail); end
        tick(0, 0);
        total++; if (b_fail !== 1'b1 || b_failc !== 16'd1) begin bad++; $display("FAIL win_upper_fail fail=%b cnt=%0d want 1/1", b_fail, b_failc); end
        tick(0, 1);
        total++; if (b_succ !== 1'b0) begin bad++; $display("FAIL win_after got=%b want=0", b_succ); end
        tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 0); tick(0, 1);
        total++; if (b_succ !== 1'b1 || b_pass !== 16'd3) begin bad++; $display("FAIL win_upper_pass succ=%b pass=%0d want 1/3", b_succ, b_pass); end
        // two attempts at ages 3 and 2 resolve on one edge
        tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 1);
        total++; if (b_succ !== 1'b1 || b_pass !== 16'd5 || b_inflight !== 3'd0) begin bad++; $display("FAIL win_multi succ=%b pass=%0d inflight=%0d want 1/5/0", b_succ, b_pass, b_inflight); end
    endtask

    task automatic test_overflow();
        do_reset();
        tick(1, 0); tick(1, 0);
        total++; if (c_inflight !== 2'd2 || c_ovf !== 1'b0) begin bad++; $display("FAIL ovf_fill inflight=%0d ovf=%b want 2/0", c_inflight, c_ovf); end
        tick(1, 0);
        total++; if (c_ovf !== 1'b1 || c_ovfc !== 16'd1 || c_inflight !== 2'd2) begin bad++; $display("FAIL ovf_drop ovf=%b cnt=%0d inflight=%0d want 1/1/2", c_ovf, c_ovfc, c_inflight); end
        tick(0, 0);
        total++; if (c_ovf !== 1'b0) begin bad++; $display("FAIL ovf_pulse got=%b want=0", c_ovf); end
        // slot 0 releases at this edge but cannot take the new trigger
        tick(1, 1);
        total++; if (c_succ !== 1'b1 || c_ovf !== 1'b1 || c_ovfc !== 16'd2 || c_inflight !== 2'd1) begin bad++; $display("FAIL ovf_reuse succ=%b ovf=%b cnt=%0d inflight=%0d want 1/1/2/1", c_succ, c_ovf, c_ovfc, c_inflight); end
        tick(0, 1);
        total++; if (c_succ !== 1'b1 || c_pass !== 16'd2 || c_busy !== 1'b0) begin bad++; $display("FAIL ovf_drain succ=%b pass=%0d busy=%b want 1/2/0", c_succ, c_pass, c_busy); end
        en = 1'b0;
        tick(1, 0);
        total++; if (c_busy !== 1'b0 || c_ovf !== 1'b0) begin bad++; $display("FAIL en_off busy=%b ovf=%b want 0/0", c_busy, c_ovf); end
        en = 1'b1;
    endtask

    task automatic test_flush();
        do_reset();
        tick(1, 0); tick(1, 0);
        flush = 1'b1;
        tick(1, 1);
        flush = 1'b0;
        total++; if (a_inflight !== 3'd0 || a_busy !== 1'b0 || a_succ !== 1'b0) begin bad++; $display("FAIL flush_clear inflight=%0d busy=%b succ=%b want 0/0/0", a_inflight, a_busy, a_succ); end
        total++; if (c_ovf !== 1'b0 || c_ovfc !== 16'd0) begin bad++; $display("FAIL flush_noovf ovf=%b cnt=%0d want 0/0", c_ovf, c_ovfc); end
        for (int i = 0; i < 4; i++) begin
            tick(0, i[0]);
            total++; if (a_succ !== 1'b0 || a_fail !== 1'b0) begin bad++; $display("FAIL flush_quiet%0d succ=%b fail=%b want 0/0", i, a_succ, a_fail); end
        end
        total++; if (a_pass !== 16'd0 || a_failc !== 16'd0) begin bad++; $display("FAIL flush_cnt pass=%0d fail=%0d want 0/0", a_pass, a_failc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1, 0); tick(1, 0);
        #2 grst = 1'b1;
        #1;
        total++; if (a_busy !== 1'b0 || a_inflight !== 3'd0) begin bad++; $display("FAIL arst busy=%b inflight=%0d want 0/0", a_busy, a_inflight); end
        #1 grst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(0, 1);
            total++; if (a_succ !== 1'b0 || a_fail !== 1'b0) begin bad++; $display("FAIL arst_quiet%0d succ=%b fail=%b want 0/0", i, a_succ, a_fail); end
        end
        total++; if ({a_pass, a_failc, a_ovfc} !== 48'd0) begin bad++; $display("FAIL arst_cnt got=%0d/%0d/%0d want 0", a_pass, a_failc, a_ovfc); end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int n = 1; n <= 5; n++) begin
            tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1);
            total++; if (d_pass !== ((n > 3) ? 2'd3 : 2'(n))) begin bad++; $display("FAIL sat%0d got=%0d want=%0d", n, d_pass, (n > 3) ? 3 : n); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1, 1);
            total++; if (a_succ !== 1'(i >= 3)) begin bad++; $display("FAIL b2b_succ%0d got=%b want=%b", i, a_succ, 1'(i >= 3)); end
        end
        total++; if (a_pass !== 16'd7 || a_inflight !== 3'd3 || a_ovfc !== 16'd0) begin bad++; $display("FAIL b2b_end pass=%0d inflight=%0d ovf=%0d want 7/3/0", a_pass, a_inflight, a_ovfc); end
        total++; if (d_pass !== 2'd3) begin bad++; $display("FAIL b2b_sat got=%0d want=3", d_pass); end
    endtask

    initial begin
        total = 0; bad = 0;
        grst = 1'b1; en = 1'b1; flush = 1'b0; trig = 1'b0; cons = 1'b0;
        test_reset();
        test_exact_pass();
        test_exact_fail();
        test_window();
        test_overflow();
        test_flush();
        test_reset_mid();
        test_saturate();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
